// File: rtl/coin_payout_if.sv
// coin_payout_if: hopper-side four-phase dispense handshake and stock-empty flags.
interface coin_payout_if;
    logic coin_req;
    logic coin_sel;
    logic coin_ack;
    logic empty_two;
    logic empty_one;
    modport master (output coin_req, coin_sel, input coin_ack, empty_two, empty_one);
    modport slave (input coin_req, coin_sel, output coin_ack, empty_two, empty_one);
endinterface

// File: rtl/coin_payout.sv
// coin_payout: greedy 2/1-rupee change payout driving a four-phase coin hopper,
// with stock-empty fallback, ack timeout and fault report of the unpaid amount.
module coin_payout #(
    parameter int AMT_W   = 4,
    parameter int TIMEOUT = 16,
    parameter int TMR_W   = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    coin_payout_if.master    hop,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining
);
    typedef enum logic [2:0] {IDLE, SELECT, REQ, RELEASE, DONE, FAULT} state_t;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [AMT_W-1:0] ONE = AMT_W'(1);
    localparam logic [AMT_W-1:0] TWO = AMT_W'(2);
    state_t state, state_d;
    logic [AMT_W-1:0] rem_d;
    logic sel_q, sel_d;
    logic [TMR_W-1:0] tmr, tmr_d;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            sel_q     <= 1'b0;
            tmr       <= '0;
        end else begin
            state     <= state_d;
            remaining <= rem_d;
            sel_q     <= sel_d;
            tmr       <= tmr_d;
        end
    // Ack beats timeout: it is tested first in REQ.
    always_comb begin
        state_d = state;
        rem_d   = remaining;
        sel_d   = sel_q;
        tmr_d   = tmr;
        case (state)
            IDLE:
                if (start) begin
                    rem_d   = amount;
                    state_d = SELECT;
                end
            SELECT:
                if (remaining == '0) state_d = DONE;
                else if (remaining >= TWO && !hop.empty_two) begin
                    sel_d   = 1'b1;
                    tmr_d   = '0;
                    state_d = REQ;
                end else if (!hop.empty_one) begin
                    sel_d   = 1'b0;
                    tmr_d   = '0;
                    state_d = REQ;
                end else state_d = FAULT;
            REQ: begin
                tmr_d = tmr + TMR_W'(1);
                if (hop.coin_ack) begin
                    rem_d   = remaining - (sel_q ? TWO : ONE);
                    state_d = RELEASE;
                end else if (tmr == TMR_LAST) state_d = FAULT;
            end
            RELEASE:     state_d = hop.coin_ack ? RELEASE : SELECT;
            DONE, FAULT: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end
    assign hop.coin_req = (state == REQ);
    assign hop.coin_sel = sel_q;
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign fault = (state == FAULT);
endmodule

// File: tb/tb_coin_payout.sv
// tb_coin_payout: directed scenarios for coin_payout with a cycle-stepped hopper model.
module tb_coin_payout;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic [3:0] amount = '0;
    logic busy, done, fault;
    logic [3:0] remaining;
    int checks = 0;
    int errors = 0;
    int n_runs, n_req_cyc, max_req, n_done, n_fault, pulse_cyc, sel_bad;
    logic busy_after;
    logic [7:0] sel_log;
    logic [3:0] rem_log [8];

    coin_payout_if hop();

    coin_payout #(.AMT_W(4), .TIMEOUT(16), .TMR_W(5)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .amount(amount), .hop(hop),
        .busy(busy), .done(done), .fault(fault), .remaining(remaining)
    );

    always #5 clock = ~clock;

    // Pulses start with amount a, then plays hopper: raise ack on the ack_delay-th
    // cycle of a req run (never if negative), drop it on the first cycle req is low.
    task automatic run(input logic [3:0] a, input int ack_delay, input int restart_cyc, input int budget);
        int run_len = 0;
        logic prev_req = 1'b0;
        logic prev_sel = 1'b0;
        n_runs = 0; n_req_cyc = 0; max_req = 0; n_done = 0; n_fault = 0;
        pulse_cyc = -1; sel_bad = 0; busy_after = 1'b1; sel_log = '0;
        @(negedge clock);
        start = 1'b1;
        amount = a;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clock);
            start = (c == restart_cyc);
            if (c == restart_cyc) amount = 4'd7;
            if (hop.coin_req) begin
                run_len++;
                n_req_cyc++;
                if (prev_req && hop.coin_sel !== prev_sel) sel_bad++;
                if (run_len == ack_delay) hop.coin_ack = 1'b1;
            end else begin
                if (prev_req && n_runs < 8) begin
                    sel_log[n_runs] = prev_sel;
                    rem_log[n_runs] = remaining;
                    n_runs++;
                    if (run_len > max_req) max_req = run_len;
                end
                run_len = 0;
                hop.coin_ack = 1'b0;
            end
            prev_req = hop.coin_req;
            prev_sel = hop.coin_sel;
            if (pulse_cyc >= 0) begin
                busy_after = busy;
                break;
            end
            if (done || fault) begin
                pulse_cyc = c;
                n_done += int'(done);
                n_fault += int'(fault);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++; if (hop.coin_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", hop.coin_req); end
        checks++; if (hop.coin_sel !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b expected 0", hop.coin_sel); end
        checks++; if ({busy, done, fault} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, fault}); end
        checks++; if (remaining !== 4'd0) begin errors++; $display("FAIL reset_remaining: got %0d expected 0", remaining); end
        reset_n = 1'b1;
    endtask

    task automatic test_greedy();
        hop.empty_two = 1'b0; hop.empty_one = 1'b0;
        run(4'd5, 2, 0, 60);
        checks++; if (n_runs !== 3) begin errors++; $display("FAIL greedy_handshakes: got %0d expected 3", n_runs); end
        checks++; if (sel_log[2:0] !== 3'b011) begin errors++; $display("FAIL greedy_sel: got %b expected 011", sel_log[2:0]); end
        checks++; if ({rem_log[0], rem_log[1], rem_log[2]} !== {4'd3, 4'd1, 4'd0}) begin errors++; $display("FAIL greedy_rem: got %0d,%0d,%0d expected 3,1,0", rem_log[0], rem_log[1], rem_log[2]); end
        checks++; if (n_done !== 1 || n_fault !== 0) begin errors++; $display("FAIL greedy_pulse: got done %0d fault %0d expected 1 0", n_done, n_fault); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL greedy_busy_after: got %b expected 0", busy_after); end
        checks++; if (sel_bad !== 0) begin errors++; $display("FAIL greedy_sel_stable: got %0d changes expected 0", sel_bad); end
    endtask

    task automatic test_empty_two();
        hop.empty_two = 1'b1; hop.empty_one = 1'b0;
        run(4'd3, 2, 0, 60);
        checks++; if (n_runs !== 3) begin errors++; $display("FAIL e2_handshakes: got %0d expected 3", n_runs); end
        checks++; if (sel_log[2:0] !== 3'b000) begin errors++; $display("FAIL e2_sel: got %b expected 000", sel_log[2:0]); end
        checks++; if ({rem_log[0], rem_log[1], rem_log[2]} !== {4'd2, 4'd1, 4'd0}) begin errors++; $display("FAIL e2_rem: got %0d,%0d,%0d expected 2,1,0", rem_log[0], rem_log[1], rem_log[2]); end
        checks++; if (n_done !== 1 || n_fault !== 0) begin errors++; $display("FAIL e2_pulse: got done %0d fault %0d expected 1 0", n_done, n_fault); end
        checks++; if (remaining !== 4'd0) begin errors++; $display("FAIL e2_remaining: got %0d expected 0", remaining); end
    endtask

    task automatic test_both_empty();
        hop.empty_two = 1'b1; hop.empty_one = 1'b1;
        run(4'd4, 2, 0, 20);
        checks++; if (n_req_cyc !== 0) begin errors++; $display("FAIL empty_req: got %0d req cycles expected 0", n_req_cyc); end
        checks++; if (n_fault !== 1 || n_done !== 0) begin errors++; $display("FAIL empty_pulse: got fault %0d done %0d expected 1 0", n_fault, n_done); end
        checks++; if (pulse_cyc !== 2) begin errors++; $display("FAIL empty_latency: got %0d expected 2", pulse_cyc); end
        checks++; if (remaining !== 4'd4) begin errors++; $display("FAIL empty_remaining: got %0d expected 4", remaining); end
    endtask

    task automatic test_timeout();
        hop.empty_two = 1'b0; hop.empty_one = 1'b0;
        run(4'd2, -1, 0, 40);
        checks++; if (n_runs !== 1 || max_req !== 16) begin errors++; $display("FAIL timeout_req_len: got %0d runs of %0d expected 1 of 16", n_runs, max_req); end
        checks++; if (n_fault !== 1 || n_done !== 0) begin errors++; $display("FAIL timeout_pulse: got fault %0d done %0d expected 1 0", n_fault, n_done); end
        checks++; if (pulse_cyc !== 18) begin errors++; $display("FAIL timeout_latency: got %0d expected 18", pulse_cyc); end
        checks++; if (remaining !== 4'd2) begin errors++; $display("FAIL timeout_remaining: got %0d expected 2", remaining); end
    endtask

    task automatic test_ack_at_limit();
        hop.empty_two = 1'b0; hop.empty_one = 1'b0;
        run(4'd2, 16, 0, 40);
        checks++; if (n_runs !== 1 || max_req !== 16) begin errors++; $display("FAIL limit_req_len: got %0d runs of %0d expected 1 of 16", n_runs, max_req); end
        checks++; if (n_done !== 1 || n_fault !== 0) begin errors++; $display("FAIL limit_pulse: got done %0d fault %0d expected 1 0", n_done, n_fault); end
        checks++; if (remaining !== 4'd0) begin errors++; $display("FAIL limit_remaining: got %0d expected 0", remaining); end
    endtask

    task automatic test_zero();
        hop.empty_two = 1'b0; hop.empty_one = 1'b0;
        run(4'd0, 2, 0, 20);
        checks++; if (n_req_cyc !== 0) begin errors++; $display("FAIL zero_req: got %0d req cycles expected 0", n_req_cyc); end
        checks++; if (n_done !== 1 || pulse_cyc !== 2) begin errors++; $display("FAIL zero_done: got %0d pulses at cycle %0d expected 1 at 2", n_done, pulse_cyc); end
    endtask

    task automatic test_busy_restart();
        hop.empty_two = 1'b0; hop.empty_one = 1'b0;
        run(4'd5, 2, 4, 60);
        checks++; if (n_runs !== 3 || sel_log[2:0] !== 3'b011) begin errors++; $display("FAIL restart_seq: got %0d runs sel %b expected 3 runs sel 011", n_runs, sel_log[2:0]); end
        checks++; if (rem_log[0] !== 4'd3 || remaining !== 4'd0) begin errors++; $display("FAIL restart_rem: got first %0d final %0d expected 3 0", rem_log[0], remaining); end
        checks++; if (n_done !== 1 || busy_after !== 1'b0) begin errors++; $display("FAIL restart_end: got done %0d busy %b expected 1 0", n_done, busy_after); end
    endtask

    task automatic test_async_reset();
        int w = 0;
        hop.empty_two = 1'b0; hop.empty_one = 1'b0; hop.coin_ack = 1'b0;
        @(negedge clock);
        start = 1'b1; amount = 4'd5;
        @(negedge clock);
        start = 1'b0;
        while (!hop.coin_req && w < 10) begin @(negedge clock); w++; end
        checks++; if (hop.coin_req !== 1'b1) begin errors++; $display("FAIL areset_pre_req: got %b expected 1", hop.coin_req); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (hop.coin_req !== 1'b0) begin errors++; $display("FAIL areset_req: got %b expected 0", hop.coin_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
        checks++; if (remaining !== 4'd0) begin errors++; $display("FAIL areset_remaining: got %0d expected 0", remaining); end
        @(negedge clock);
        reset_n = 1'b1;
        run(4'd1, 2, 0, 30);
        checks++; if (n_runs !== 1 || sel_log[0] !== 1'b0) begin errors++; $display("FAIL areset_after_seq: got %0d runs sel %b expected 1 run sel 0", n_runs, sel_log[0]); end
        checks++; if (n_done !== 1 || remaining !== 4'd0) begin errors++; $display("FAIL areset_after_done: got done %0d remaining %0d expected 1 0", n_done, remaining); end
    endtask

    initial begin
        hop.coin_ack = 1'b0;
        hop.empty_two = 1'b0;
        hop.empty_one = 1'b0;
        test_reset();
        test_greedy();
        test_empty_two();
        test_both_empty();
        test_timeout();
        test_ack_at_limit();
        test_zero();
        test_busy_restart();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/coin_payout.md
Name: coin_payout

Overview:
- Payout end of the coin path: takes a change amount in rupees and drives the coin hopper to dispense 2-rupee and 1-rupee coins one at a time.
- Uses a four-phase req/ack handshake with the hopper.
- Sits downstream of the coin-acceptance FSM: that FSM computes the change amount, this block physically returns it.
- Greedy payout with per-denomination stock-empty flags, an ack timeout, and a fault report of any undispensed amount.

Parameters:
- AMT_W, 4, width of amount and remaining, in rupees.
- TIMEOUT, 16, cycles coin_req may wait for coin_ack before a fault is declared (TIMEOUT >= 2).
- TMR_W, 5, timeout counter width; must hold TIMEOUT.

Ports:
- clock  in  1  rising-edge system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to pay out amount; sampled in IDLE only.
- amount  in  AMT_W  change to pay, in rupees; sampled with start.
- empty_two  in  1  hopper has no 2-rupee coins.
- empty_one  in  1  hopper has no 1-rupee coins.
- coin_ack  in  1  hopper acknowledge (four-phase).
- coin_req  out  1  dispense request to hopper.
- coin_sel  out  1  denomination: 1 = 2-rupee, 0 = 1-rupee; stable while coin_req = 1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the full amount has been paid.
- fault  out  1  one-cycle pulse when payout was aborted.
- remaining  out  AMT_W  rupees still owed; holds its value after done/fault until the next accepted start.

Behaviour:
- Reset (async, reset_n = 0):
  - state = IDLE.
  - coin_req, coin_sel, busy, done, fault and remaining all = 0, and the timer = 0.
  - Takes effect immediately, mid-handshake included: coin_req drops without waiting for coin_ack.
- Outputs are registered or decoded from the registered state. No combinational path from an input to coin_req, done or fault.
- States: IDLE, SELECT, REQ, RELEASE, DONE, FAULT.
- IDLE:
  - start = 1: remaining <= amount, then go to SELECT.
  - start while busy is ignored.
- SELECT (1 cycle), first matching rule wins:
  - remaining = 0: go to DONE.
  - remaining >= 2 and !empty_two: coin_sel <= 1, go to REQ.
  - remaining >= 1 and !empty_one: coin_sel <= 0, go to REQ.
  - otherwise: go to FAULT.
  - amount = 0 therefore produces done 2 cycles after start with no coin_req.
- REQ:
  - coin_req = 1; the timer clears on entry and increments each cycle.
  - coin_ack = 1: remaining <= remaining - (coin_sel ? 2 : 1), go to RELEASE.
  - Timer reaches TIMEOUT - 1 with no ack: go to FAULT, remaining unchanged.
  - If ack arrives on the same cycle the timeout is reached, the ack wins.
- RELEASE:
  - coin_req = 0.
  - Wait for coin_ack = 0, then go to SELECT. No timeout in this state.
  - Stock flags are re-evaluated in SELECT for every coin.
- DONE: done = 1 for one cycle, then IDLE.
- FAULT: fault = 1 for one cycle, then IDLE; remaining reports the amount still owed.
- Arithmetic:
  - remaining never underflows: a 2-rupee coin is selected only when remaining >= 2.
  - Subtraction is AMT_W-bit unsigned.
- Illegal or unreachable state encodings go to IDLE.
- coin_ack held high on entering REQ (hopper violating four-phase):
  - It is accepted in REQ's first cycle.
  - RELEASE then blocks until the ack falls.

Test Plan:
- amount=5, both stocks present, hopper acks 2 cycles after req and drops ack 1 cycle after req falls -> three handshakes with coin_sel 1,1,0; remaining 5→3→1→0; one done pulse; busy low afterwards.
- amount=3, empty_two=1 -> three handshakes, all coin_sel=0; done pulse; remaining=0; fault never high.
- amount=4, empty_two=1 and empty_one=1 -> no coin_req; fault pulse 2 cycles after start; remaining=4.
- amount=2, hopper never acks, TIMEOUT=16 -> coin_req high for exactly 16 cycles then low; fault pulse; remaining=2. Repeat with ack on the 16th cycle -> accepted, done, remaining=0.
- amount=0 -> done exactly 2 cycles after start, no coin_req. start pulsed again while busy during a 5-rupee payout -> ignored; payout completes as in scenario 1.
- reset_n low for 1 cycle while coin_req=1 mid-payout -> coin_req, busy and remaining go to 0 asynchronously. After release, a new start with amount=1 pays one 1-rupee coin normally.
